// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the req/ack <-> stream bridges.
//   hs_state_e   : receiver handshake FSM states (IDLE, ACKED, WAITLOW)
//   BRIDGE_WIDTH : default data word width used by both bridge directions
package bridge_pkg;
    localparam int BRIDGE_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACKED   = 2'b01,
        WAITLOW = 2'b10
    } hs_state_e;
endpackage

// File: rtl/handshake_to_stream_if.sv
// handshake_to_stream_if: bundles the req/ack handshake side and the valid/ready stream side.
//   req, data_in        : from the 4-phase sender
//   ack                 : back to the sender
//   valid, data_out     : to the stream consumer
//   ready               : from the stream consumer
//   level               : buffered word count
//   modport slave  : the bridge itself
//   modport master : the surrounding logic (sender + consumer)
interface handshake_to_stream_if import bridge_pkg::*; #(
    parameter int WIDTH = BRIDGE_WIDTH,
    parameter int DEPTH = 4
) ();
    logic                     req;
    logic                     ack;
    logic [WIDTH-1:0]         data_in;
    logic                     valid;
    logic                     ready;
    logic [WIDTH-1:0]         data_out;
    logic [$clog2(DEPTH):0]   level;

    modport slave  (input req, data_in, ready, output ack, valid, data_out, level);
    modport master (output req, data_in, ready, input ack, valid, data_out, level);
endinterface

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: first-word-fall-through FIFO buffering captured handshake words.
//   clk, rst  : clock, asynchronous active-low reset
//   wr_en     : push data_in (ignored when full)
//   rd_en     : pop head word (ignored when empty)
//   data_out  : head word, 0 when empty
//   full      : level == DEPTH
//   empty     : level == 0
//   level     : occupancy, one bit wider than the pointers so it can reach DEPTH
module hs_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full     = level == (AW+1)'(DEPTH);
    assign empty    = level == '0;
    assign wr       = wr_en && !full;
    assign rd       = rd_en && !empty;
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            level  <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data_in;
    end
endmodule

// File: rtl/handshake_to_stream.sv
// handshake_to_stream: receiver bridge from a 4-phase req/ack handshake to a valid/ready stream.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   en   : when 0, no new handshake is started (an in-flight one still completes)
//   bus  : handshake_to_stream_if.slave (req/ack/data_in, valid/ready/data_out, level)
// Build option: define HS2S_REQ_SYNC_EN to pass req through a 2-flop synchronizer
// for senders in another clock domain (req-to-ack latency becomes 3 cycles).
module handshake_to_stream import bridge_pkg::*; #(
    parameter int WIDTH = BRIDGE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    handshake_to_stream_if.slave  bus
);
    logic      req_i;
    logic      full;
    logic      empty;
    logic      wr_en;
    hs_state_e state;
    hs_state_e state_nxt;

`ifdef HS2S_REQ_SYNC_EN
    logic [1:0] req_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) req_sync <= '0;
        else      req_sync <= {req_sync[0], bus.req};
    end

    assign req_i = req_sync[1];
`else
    assign req_i = bus.req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Capture happens only on the IDLE->ACKED edge, so a req held high after ack
    // cannot write twice; WAITLOW forces one ack-low cycle between words.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                wr_en     = req_i && en && !full;
                state_nxt = wr_en ? ACKED : IDLE;
            end
            ACKED:   state_nxt = req_i ? ACKED : WAITLOW;
            WAITLOW: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack is a decode of the state register, so it drops as soon as rst clears it.
    assign bus.ack   = state == ACKED;
    assign bus.valid = !empty;

    hs_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (bus.ready),
        .data_in  (bus.data_in),
        .data_out (bus.data_out),
        .full     (full),
        .empty    (empty),
        .level    (bus.level)
    );
endmodule
